// File: rtl/axil_uart_ctrl_v2.sv
// rtl/axil_uart_ctrl_v2.sv - AXI4-Lite register front end for the UART core
// Holds TX/RX byte FIFOs, CONFIG/STATUS/IRQ registers, RTS flow control and a level interrupt.
module axil_uart_ctrl_v2 #(
  parameter int          ADDR_W     = 16,
  parameter int          TX_DEPTH   = 16,
  parameter int          RX_DEPTH   = 16,
  parameter int          RX_THRESH  = 1,
  parameter int          RTS_MARGIN = 2,
  parameter logic [31:0] CONFIG_RST = 32'h8400_01B2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [23:0]       div_num,
  output logic [3:0]        data_bit,
  output logic [1:0]        stop_bit,
  output logic [1:0]        check_bit,
  output logic              rts,
  output logic              irq
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int TLW = TPW + 1;
  localparam int RLW = RPW + 1;
  localparam logic [TLW-1:0] TX_FULL_LVL = TLW'(TX_DEPTH);
  localparam logic [RLW-1:0] RX_FULL_LVL = RLW'(RX_DEPTH);
  localparam logic [RLW-1:0] RX_THR_LVL  = RLW'(RX_THRESH);
  localparam logic [RLW-1:0] RTS_LVL     = RLW'(RX_DEPTH - RTS_MARGIN);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TPW-1:0] tx_wptr, tx_rptr;
  logic [RPW-1:0] rx_wptr, rx_rptr;
  logic [TLW-1:0] tx_lvl;
  logic [RLW-1:0] rx_lvl, rx_lvl_nxt;
  logic [31:0]    cfg, status, rd_data;
  logic [2:0]     irq_en, irq_pend;
  logic [1:0]     wr_resp, rd_resp;
  logic           aw_rdy, overrun;

  logic [2:0] wr_idx, rd_idx;
  logic       wr_ok, rd_ok, wr_hs, rd_hs;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, rx_push, rx_pop, ovr_clr;
  logic       unused_addr_lsbs;

  assign wr_idx = s_axi_awaddr[4:2];
  assign rd_idx = s_axi_araddr[4:2];
  assign wr_ok  = (s_axi_awaddr[ADDR_W-1:5] == '0);
  assign rd_ok  = (s_axi_araddr[ADDR_W-1:5] == '0);
  assign wr_hs  = aw_rdy & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs  = s_axi_arready & s_axi_arvalid;
  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = aw_rdy;

  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = (tx_lvl == TX_FULL_LVL);
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = (rx_lvl == RX_FULL_LVL);
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rptr];

  // Full/empty are sampled before this cycle's opposite-side pop/push.
  assign tx_push = wr_hs & wr_ok & (wr_idx == 3'd1) & s_axi_wstrb[0] & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = rd_hs & rd_ok & (rd_idx == 3'd0) & ~rx_empty;
  assign ovr_clr = wr_hs & wr_ok & (wr_idx == 3'd5) & s_axi_wstrb[0] & s_axi_wdata[2];

  assign div_num   = cfg[23:0];
  assign data_bit  = cfg[31:28];
  assign stop_bit  = cfg[27:26];
  assign check_bit = cfg[25:24];

  assign status   = {8'b0, 8'(tx_lvl), 8'(rx_lvl), 3'b0, overrun, tx_full, tx_empty, rx_full, rx_empty};
  assign irq_pend = {overrun, tx_empty, (rx_lvl >= RX_THR_LVL)};

  always_comb begin
    rx_lvl_nxt = rx_lvl;
    if (rx_push && !rx_pop)      rx_lvl_nxt = rx_lvl + 1'b1;
    else if (!rx_push && rx_pop) rx_lvl_nxt = rx_lvl - 1'b1;
  end

  always_comb begin
    wr_resp = OKAY;
    if (!wr_ok) begin
      wr_resp = SLVERR;
    end else begin
      case (wr_idx)
        3'd0:                    wr_resp = SLVERR;
        3'd1:                    if (s_axi_wstrb[0] && tx_full) wr_resp = SLVERR;
        3'd2, 3'd3, 3'd4, 3'd5:  wr_resp = OKAY;
        default:                 wr_resp = SLVERR;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    if (!rd_ok) begin
      rd_resp = SLVERR;
    end else begin
      case (rd_idx)
        3'd0: begin
          if (rx_empty) rd_resp = SLVERR;
          else          rd_data = {1'b1, 23'b0, rx_mem[rx_rptr]};
        end
        3'd1:    rd_data = '0;
        3'd2:    rd_data = cfg;
        3'd3:    rd_data = status;
        3'd4:    rd_data = {29'b0, irq_en};
        3'd5:    rd_data = {29'b0, irq_pend};
        default: rd_resp = SLVERR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_rdy        <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
    end else begin
      aw_rdy        <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~aw_rdy;
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wptr] <= s_axi_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_lvl  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_lvl  <= '0;
      cfg     <= CONFIG_RST;
      irq_en  <= 3'b0;
      overrun <= 1'b0;
      rts     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_lvl <= tx_lvl + 1'b1;
      else if (!tx_push && tx_pop) tx_lvl <= tx_lvl - 1'b1;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      rx_lvl <= rx_lvl_nxt;
      rts    <= (rx_lvl_nxt >= RTS_LVL);
      irq    <= |(irq_en & irq_pend);
      // A byte lost this cycle outranks a simultaneous W1C.
      if (rx_valid && rx_full) overrun <= 1'b1;
      else if (ovr_clr)        overrun <= 1'b0;
      if (wr_hs && wr_ok && wr_idx == 3'd2) begin
        for (int b = 0; b < 4; b++)
          if (s_axi_wstrb[b]) cfg[8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
      if (wr_hs && wr_ok && wr_idx == 3'd4 && s_axi_wstrb[0]) irq_en <= s_axi_wdata[2:0];
    end
  end
endmodule

// File: tb/tb_axil_uart_ctrl_v2.sv
// tb/tb_axil_uart_ctrl_v2.sv - scoreboard bench for axil_uart_ctrl_v2
module tb_axil_uart_ctrl_v2;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b1;
  logic [15:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [23:0] div_num;
  logic [3:0]  data_bit;
  logic [1:0]  stop_bit, check_bit;
  logic        rts, irq;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  logic [7:0] exp_tx[$];
  int n_cmp = 0;
  int n_err = 0;

  axil_uart_ctrl_v2 dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .div_num(div_num), .data_bit(data_bit), .stop_bit(stop_bit), .check_bit(check_bit),
    .rts(rts), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got 0 expected 1", name);
  endtask

  // Monitors: each response is visible on exactly one falling edge since ready is held high.
  always @(negedge clock) begin
    if (reset && s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 32'(s_axi_bresp), 32'hDEAD);
      else check("bresp", 32'(s_axi_bresp), 32'(exp_b.pop_front()));
    end
  end

  always @(negedge clock) begin
    rexp_t e;
    if (reset && s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) begin
        check("r_unexpected", s_axi_rdata, 32'hDEAD_BEEF);
      end else begin
        e = exp_r.pop_front();
        check("rdata", s_axi_rdata, e.data);
        check("rresp", 32'(s_axi_rresp), 32'(e.resp));
      end
    end
  end

  always @(negedge clock) begin
    if (reset && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_data), 32'h1FF);
      else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
  end

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    bit seen = 0;
    exp_b.push_back(er);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = s_axi_awready && s_axi_wready;
    end
    if (!seen) timeout("aw_handshake");
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit seen = 0;
    exp_r.push_back('{data: ed, resp: er});
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = s_axi_arready;
    end
    if (!seen) timeout("ar_handshake");
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // Reset state
    check("rst_awready", 32'(s_axi_awready), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_rts", 32'(rts), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_div_num", 32'(div_num), 434);
    check("rst_data_bit", 32'(data_bit), 8);
    check("rst_stop_bit", 32'(stop_bit), 1);
    check("rst_check_bit", 32'(check_bit), 0);
    axi_read(16'h08, 32'h8400_01B2, 2'b00);
    axi_read(16'h0C, 32'h0000_0005, 2'b00);

    // Three TX bytes, then drain
    axi_write(16'h04, 32'h41, 4'h1, 2'b00);
    axi_write(16'h04, 32'h42, 4'h1, 2'b00);
    axi_write(16'h04, 32'h43, 4'h1, 2'b00);
    axi_read(16'h0C, 32'h0003_0001, 2'b00);
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h42); exp_tx.push_back(8'h43);
    tx_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1 check("tx_drained3", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // wstrb[0]=0 to TXDATA: OKAY, no push
    axi_write(16'h04, 32'h99, 4'h2, 2'b00);
    axi_read(16'h0C, 32'h0000_0005, 2'b00);

    // Fill TX, 17th byte rejected
    for (int i = 0; i < 16; i++) axi_write(16'h04, 32'h60 + i, 4'h1, 2'b00);
    axi_write(16'h04, 32'hEE, 4'h1, 2'b10);
    axi_read(16'h0C, 32'h0010_0009, 2'b00);
    for (int i = 0; i < 16; i++) exp_tx.push_back(8'(8'h60 + i));
    tx_ready = 1'b1;
    repeat (24) @(posedge clock);
    #1 check("tx_drained16", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // CONFIG lanes, unmapped and odd accesses
    axi_write(16'h08, 32'h1234_5678, 4'b0011, 2'b00);
    axi_read(16'h08, 32'h8400_5678, 2'b00);
    check("cfg_div_num", 32'(div_num), 32'h5678);
    axi_read(16'h18, 32'h0, 2'b10);
    axi_write(16'h1C, 32'h1, 4'hF, 2'b10);
    axi_read(16'h0108, 32'h0, 2'b10);
    axi_write(16'h00, 32'h1, 4'hF, 2'b10);
    axi_read(16'h04, 32'h0, 2'b00);
    axi_write(16'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00);

    // RX overrun and RTS
    for (int i = 0; i < 17; i++) begin
      rx_pulse(8'(i));
      if (i == 12) check("rts_13", 32'(rts), 0);
      if (i == 13) check("rts_14", 32'(rts), 1);
    end
    axi_read(16'h0C, 32'h0000_1016, 2'b00);
    axi_read(16'h14, 32'h7, 2'b00);
    for (int i = 0; i < 16; i++) axi_read(16'h00, 32'h8000_0000 + i, 2'b00);
    axi_read(16'h00, 32'h0, 2'b10);
    check("rts_after_drain", 32'(rts), 0);
    axi_write(16'h14, 32'h4, 4'h1, 2'b00);
    axi_read(16'h14, 32'h2, 2'b00);

    // IRQ from RX threshold
    axi_write(16'h10, 32'h1, 4'h1, 2'b00);
    check("irq_idle", 32'(irq), 0);
    rx_pulse(8'h55);
    check("irq_1cyc", 32'(irq), 0);
    @(posedge clock); #1;
    check("irq_rx", 32'(irq), 1);
    axi_read(16'h00, 32'h8000_0055, 2'b00);
    check("irq_rx_clr", 32'(irq), 0);

    // IRQ from overrun, cleared by W1C
    axi_write(16'h10, 32'h4, 4'h1, 2'b00);
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'hA0 + i));
    @(posedge clock); #1;
    check("irq_full_masked", 32'(irq), 0);
    rx_pulse(8'hFF);
    @(posedge clock); #1;
    check("irq_ovr", 32'(irq), 1);
    axi_write(16'h14, 32'h4, 4'h1, 2'b00);
    check("irq_ovr_clr", 32'(irq), 0);

    // Reset with a B response pending and both FIFOs non-empty
    axi_write(16'h04, 32'h11, 4'h1, 2'b00);
    axi_write(16'h04, 32'h22, 4'h1, 2'b00);
    s_axi_bready = 1'b0;
    s_axi_awaddr = 16'h10; s_axi_wdata = 32'h7; s_axi_wstrb = 4'h1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = s_axi_bvalid;
    end
    if (!seen) timeout("bvalid_before_reset");
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("arst_bvalid", 32'(s_axi_bvalid), 0);
    check("arst_tx_valid", 32'(tx_valid), 0);
    check("arst_rts", 32'(rts), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    s_axi_bready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    axi_read(16'h0C, 32'h0000_0005, 2'b00);
    axi_read(16'h08, 32'h8400_01B2, 2'b00);
    axi_read(16'h10, 32'h0, 2'b00);
    check("arst_irq", 32'(irq), 0);

    repeat (5) @(posedge clock);
    #1;
    check("b_queue_drained", 32'(exp_b.size()), 0);
    check("r_queue_drained", 32'(exp_r.size()), 0);
    check("tx_queue_drained", 32'(exp_tx.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axil_uart_ctrl_v2.md
Name: axil_uart_ctrl_v2

Overview:
- Second-generation AXI4-Lite slave front end for the UART driver.
- Owns parametrised TX and RX byte FIFOs, a config register, a status register and a maskable interrupt.
- Connects to the UART core through byte valid/ready streams, and drives RTS from the RX FIFO fill level.
- Adds behaviour the previous front end lacked: proper write-strobe handling, SLVERR on full or empty, an overrun flag, FIFO levels and an IRQ output.

Parameters:
ADDR_W, 16, AXI address width; only addr[4:2] is decoded, and addr[ADDR_W-1:5] must be 0.
TX_DEPTH, 16, TX FIFO entries; power of 2, 2..128.
RX_DEPTH, 16, RX FIFO entries; power of 2, 2..128.
RX_THRESH, 1, RX level at or above which IRQ_PEND[0] sets; range 1..RX_DEPTH.
RTS_MARGIN, 2, RTS asserts when RX level >= RX_DEPTH-RTS_MARGIN; range 0..RX_DEPTH-1.
CONFIG_RST, 32'h8400_01B2, CONFIG reset value (data 8, stop 1, no parity, divisor 434).

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  AW channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  W channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  B channel
s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  AR channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  R channel
tx_data/tx_valid/tx_ready  out/out/in  8/1/1  byte stream to UART transmitter
rx_data/rx_valid  in/in  8/1  byte from UART receiver; one-cycle pulse per byte
div_num/data_bit/stop_bit/check_bit  out  24/4/2/2  CONFIG[23:0]/[31:28]/[27:26]/[25:24]
rts  out  1  flow control towards the remote device
irq  out  1  level interrupt, equal to |(IRQ_EN & IRQ_PEND)

Behaviour:
- Reset (asynchronous, active-low):
  - All AXI ready/valid outputs 0; bresp, rresp and rdata 0.
  - Both FIFOs emptied; tx_valid 0; CONFIG=CONFIG_RST; IRQ_EN=0; overrun=0; rts=0; irq=0.
  - Any in-flight AXI transaction is abandoned; no response is issued after reset.
- Write channel:
  - When awvalid&wvalid&~bvalid&~awready, awready and wready are both driven 1 for exactly one cycle (cycle N+1), completing AW and W together.
  - The register action happens on that handshake cycle.
  - bvalid rises at N+2 and holds until bready; no new AW/W is accepted while bvalid=1.
  - AW without W, or W without AW, is never accepted alone.
- Read channel:
  - When arvalid&~rvalid&~arready, arready is driven 1 for one cycle (N+1); the register action happens then.
  - rvalid and rdata/rresp are presented at N+2 and hold stable until rready.
  - No new AR is accepted while rvalid=1.
- Register map (byte offsets). Unmapped offsets: reads return 0 with SLVERR (2'b10); writes have no effect and return SLVERR.
  - 0x00 RXDATA, read-only. If the RX FIFO is non-empty: pop, rdata={1'b1,23'b0,byte}, OKAY. If empty: rdata=0, SLVERR, no pop. Writes return SLVERR.
  - 0x04 TXDATA, write-only. With wstrb[0]=1 and TX FIFO not full: push wdata[7:0], OKAY. With wstrb[0]=1 and full: byte dropped, SLVERR. With wstrb[0]=0: no push, OKAY. Reads return 0, OKAY.
  - 0x08 CONFIG, read/write. Byte lanes are updated per wstrb; new values appear on the config outputs the cycle after the handshake.
  - 0x0C STATUS, read-only:
    - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 overrun
    - [15:8] RX level, [23:16] TX level, zero-extended
    - writes are ignored, OKAY.
  - 0x10 IRQ_EN, read/write [2:0]; updated when wstrb[0]=1.
  - 0x14 IRQ_PEND:
    - bit0 = RX level >= RX_THRESH (level-sensitive, read-only)
    - bit1 = tx_empty (level-sensitive, read-only)
    - bit2 = overrun (sticky); writing 1 to bit2 with wstrb[0]=1 clears it.
- TX stream:
  - tx_valid = ~tx_empty; tx_data = FIFO head (first-word-fall-through).
  - Pop on tx_valid&tx_ready.
  - A simultaneous AXI push and stream pop updates the level by +1-1=0.
  - Full is evaluated before the pop, so a push into a full FIFO is SLVERR even if a pop occurs in the same cycle.
- RX stream:
  - rx_valid pushes rx_data.
  - If the FIFO is full, the byte is dropped and overrun sets, even if an AXI pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the level unchanged.
  - If rx_valid sets overrun in the same cycle that a W1C write clears it, set wins.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; levels are $clog2(DEPTH)+1 bits, range 0..DEPTH.
- rts is registered: 1 when RX level >= RX_DEPTH-RTS_MARGIN, else 0.
- irq is registered and updates one cycle after any change in IRQ_EN or IRQ_PEND.

Test Plan:
- Reset then read 0x08 -> rdata=32'h8400_01B2, OKAY; div_num=434, data_bit=8, stop_bit=1. Read 0x0C -> 32'h0000_0005.
- Write 0x04 with 8'h41, 8'h42, 8'h43 while tx_ready=0 -> three OKAY responses, STATUS[23:16]=3. Raise tx_ready -> tx_data sequence 41,42,43, then tx_valid=0.
- Fill the TX FIFO with 16 bytes (tx_ready=0), then write a 17th -> bresp=2'b10, level stays 16, and the 17th byte never appears on tx_data.
- Pulse rx_valid 17 times with bytes 0..16 -> overrun=1. rts=1 from the 14th byte onward. 16 reads return 32'h8000_0000..32'h8000_000F; the 17th read returns 0 with SLVERR.
- Set IRQ_EN=3'b001 and pulse one rx byte -> irq=1 two cycles after rx_valid. Read RXDATA -> irq=0. Set IRQ_EN=3'b100 and force an overrun -> irq=1; W1C 0x14 with 3'b100 -> irq=0.
- Assert reset while bvalid=1 and the FIFOs are non-empty -> bvalid=0 immediately, STATUS=32'h0000_0005 after release, and no stale B or R response appears.
